// File: rtl/phase5_pkg.sv
// Shared types, code constants and small helpers for the phase-5 time-lock checker.
package phase5_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ST1  = 3'd1,
    ST2  = 3'd2,
    ST3  = 3'd3,
    PASS = 3'd4,
    FAIL = 3'd5
  } state_t;

  localparam logic [1:0] TL_IDLE = 2'b00;
  localparam logic [1:0] TL_S1   = 2'b01;
  localparam logic [1:0] TL_S2   = 2'b10;
  localparam logic [1:0] TL_S3   = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ORDER = 2'b01;
  localparam logic [1:0] CAUSE_SHORT = 2'b10;
  localparam logic [1:0] CAUSE_LONG  = 2'b11;

  function automatic logic [1:0] expected_code(input state_t s);
    case (s)
      ST1:     return TL_S1;
      ST2:     return TL_S2;
      ST3:     return TL_S3;
      default: return TL_IDLE;
    endcase
  endfunction

  // The code that legally ends the dwell of each stage; ST3 hands back to 00.
  function automatic logic [1:0] next_code(input state_t s);
    case (s)
      ST1:     return TL_S2;
      ST2:     return TL_S3;
      default: return TL_IDLE;
    endcase
  endfunction

  function automatic state_t advance_state(input state_t s);
    case (s)
      ST1:     return ST2;
      ST2:     return ST3;
      ST3:     return PASS;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [1:0] stage_of(input state_t s, input logic [1:0] held);
    case (s)
      IDLE:    return 2'd0;
      ST1:     return 2'd0;
      ST2:     return 2'd1;
      ST3:     return 2'd2;
      PASS:    return 2'd3;
      FAIL:    return held;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] max);
    return (v >= max) ? max : v + 2'd1;
  endfunction

endpackage

// File: rtl/phase5_dwell_counter.sv
// Dwell counter for the current time-lock code: load-to-1, increment, and compare to DWELL.
module phase5_dwell_counter
  import phase5_pkg::*;
#(
  parameter int DWELL = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic at_dwell
);

  localparam logic [3:0] DWELL_C = 4'(DWELL);

  logic [3:0] cnt_r;

  // Counter register; clear outranks load, load outranks increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else if (clr) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= 4'd1;
    end else if (inc) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_dwell = (cnt_r == DWELL_C);

endmodule

// File: rtl/phase5_lock_checker.sv
// Receive-side checker for the phase-5 time-lock stream 01,10,11,00 with exact dwell,
// reporting pass/fail with cause and escalating to a sticky alarm.
module phase5_lock_checker
  import phase5_pkg::*;
#(
  parameter int DWELL     = 5,
  parameter int MAX_FAILS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] time_lock_in,
  input  logic       clear,
  output logic       phase5_ok,
  output logic       phase5_err,
  output logic       alarm,
  output logic [1:0] stage,
  output logic [1:0] fail_cause,
  output logic [1:0] fail_count
);

  localparam logic [1:0] MAX_FAILS_C = 2'(MAX_FAILS);

  state_t     state_r;
  state_t     nxt_state_s;
  logic       fail_now_s;
  logic [1:0] cause_nxt_s;
  logic       cnt_load_s;
  logic       cnt_inc_s;
  logic       at_dwell_s;
  logic [1:0] count_nxt_s;

  phase5_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .load     (cnt_load_s),
    .inc      (cnt_inc_s),
    .at_dwell (at_dwell_s)
  );

  // Code evaluation for the current state: next state, fail cause and counter control.
  always_comb begin
    nxt_state_s = state_r;
    fail_now_s  = 1'b0;
    cause_nxt_s = CAUSE_NONE;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        case (time_lock_in)
          TL_IDLE: nxt_state_s = IDLE;
          TL_S1: begin
            nxt_state_s = ST1;
            cnt_load_s  = 1'b1;
          end
          default: begin
            fail_now_s  = 1'b1;
            cause_nxt_s = CAUSE_ORDER;
          end
        endcase
      end
      ST1, ST2, ST3: begin
        if (time_lock_in == expected_code(state_r)) begin
          if (at_dwell_s) begin
            fail_now_s  = 1'b1;
            cause_nxt_s = CAUSE_LONG;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end else if (time_lock_in == next_code(state_r)) begin
          if (at_dwell_s) begin
            nxt_state_s = advance_state(state_r);
            cnt_load_s  = 1'b1;
          end else begin
            fail_now_s  = 1'b1;
            cause_nxt_s = CAUSE_SHORT;
          end
        end else begin
          fail_now_s  = 1'b1;
          cause_nxt_s = CAUSE_ORDER;
        end
      end
      PASS, FAIL: nxt_state_s = state_r;
      default:    nxt_state_s = IDLE;
    endcase
    if (fail_now_s) begin
      nxt_state_s = FAIL;
    end else begin
      nxt_state_s = nxt_state_s;
    end
  end

  assign count_nxt_s = sat_inc(fail_count, MAX_FAILS_C);

  // State register and registered Moore outputs; clear re-arms without touching fail bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      phase5_ok  <= 1'b0;
      phase5_err <= 1'b0;
      alarm      <= 1'b0;
      stage      <= 2'd0;
      fail_cause <= CAUSE_NONE;
      fail_count <= 2'd0;
    end else if (clear) begin
      state_r    <= IDLE;
      phase5_ok  <= 1'b0;
      phase5_err <= 1'b0;
      stage      <= 2'd0;
      fail_cause <= CAUSE_NONE;
    end else begin
      state_r    <= nxt_state_s;
      phase5_ok  <= (nxt_state_s == PASS);
      phase5_err <= (nxt_state_s == FAIL);
      stage      <= stage_of(nxt_state_s, stage);
      if (fail_now_s) begin
        fail_cause <= cause_nxt_s;
        fail_count <= count_nxt_s;
        if (count_nxt_s == MAX_FAILS_C) begin
          alarm <= 1'b1;
        end else begin
          alarm <= alarm;
        end
      end else begin
        fail_cause <= fail_cause;
        fail_count <= fail_count;
        alarm      <= alarm;
      end
    end
  end

endmodule

// File: tb/tb_phase5_lock_checker.sv
// Self-checking bench: vector table, directed corner sequences, and randomized streams
// compared against a run-length reference model of the lock sequence.
module tb_phase5_lock_checker;

  localparam int DWELL     = 5;
  localparam int MAX_FAILS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] time_lock_in;
  logic       phase5_ok;
  logic       phase5_err;
  logic       alarm;
  logic [1:0] stage;
  logic [1:0] fail_cause;
  logic [1:0] fail_count;

  always #5 clk = ~clk;

  phase5_lock_checker #(.DWELL(DWELL), .MAX_FAILS(MAX_FAILS)) dut (
    .clk          (clk),
    .reset        (reset),
    .time_lock_in (time_lock_in),
    .clear        (clear),
    .phase5_ok    (phase5_ok),
    .phase5_err   (phase5_err),
    .alarm        (alarm),
    .stage        (stage),
    .fail_cause   (fail_cause),
    .fail_count   (fail_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: samples since the checker was last armed.
  logic [1:0] hist[$];
  bit         decided;
  bit         m_ok, m_err, m_alarm;
  logic [1:0] m_cause, m_stage, m_count;

  typedef struct packed {
    logic       ok;
    logic       err;
    logic [1:0] cause;
    logic [1:0] stage;
  } verdict_t;

  typedef struct {
    logic [1:0] code;
    logic       clr;
    logic       rst;
    logic       ok;
    logic       err;
    logic [1:0] cause;
    logic [1:0] stage;
    logic [1:0] count;
    logic       alarm;
  } vec_t;

  vec_t tbl[$];

  // Judge the armed history as runs: leading 00s, then runs of 01, 10, 11, closed by 00.
  function automatic verdict_t evaluate();
    verdict_t   v;
    int         n;
    int         i;
    int         len;
    logic [1:0] code;
    logic [1:0] nxt;
    v = '0;
    n = hist.size();
    i = 0;
    while (i < n && hist[i] == 2'b00) i++;
    if (i == n) return v;
    if (hist[i] != 2'b01) begin
      v.err = 1'b1; v.cause = 2'b01;
      return v;
    end
    for (int k = 0; k < 3; k++) begin
      code = 2'(k + 1);
      nxt  = (k == 2) ? 2'b00 : 2'(k + 2);
      len  = 0;
      while (i < n && hist[i] == code) begin
        len++; i++;
      end
      v.stage = 2'(k);
      if (len > DWELL) begin
        v.err = 1'b1; v.cause = 2'b11;
        return v;
      end
      if (i == n) return v;
      if (hist[i] != nxt) begin
        v.err = 1'b1; v.cause = 2'b01;
        return v;
      end
      if (len < DWELL) begin
        v.err = 1'b1; v.cause = 2'b10;
        return v;
      end
    end
    v.ok = 1'b1; v.stage = 2'd3;
    return v;
  endfunction

  function automatic void model_step(input logic [1:0] code, input logic clr, input logic rst);
    verdict_t v;
    if (rst) begin
      hist.delete(); decided = 1'b0;
      m_ok = 1'b0; m_err = 1'b0; m_cause = 2'd0; m_stage = 2'd0;
      m_count = 2'd0; m_alarm = 1'b0;
    end else if (clr) begin
      hist.delete(); decided = 1'b0;
      m_ok = 1'b0; m_err = 1'b0; m_cause = 2'd0; m_stage = 2'd0;
    end else if (!decided) begin
      hist.push_back(code);
      v = evaluate();
      m_ok = v.ok; m_err = v.err; m_cause = v.cause; m_stage = v.stage;
      if (v.ok || v.err) decided = 1'b1;
      if (v.err) begin
        if (m_count < 2'(MAX_FAILS)) m_count = m_count + 2'd1;
        if (m_count == 2'(MAX_FAILS)) m_alarm = 1'b1;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ok, input logic err,
                            input logic [1:0] cause, input logic [1:0] stg,
                            input logic [1:0] cnt, input logic alm);
    check({tag, ".ok"},    int'(phase5_ok),  int'(ok));
    check({tag, ".err"},   int'(phase5_err), int'(err));
    check({tag, ".cause"}, int'(fail_cause), int'(cause));
    check({tag, ".stage"}, int'(stage),      int'(stg));
    check({tag, ".count"}, int'(fail_count), int'(cnt));
    check({tag, ".alarm"}, int'(alarm),      int'(alm));
  endtask

  // One clock: apply inputs, advance the model, and compare every output against it.
  task automatic step(input logic [1:0] code, input logic clr, input logic rst);
    time_lock_in = code; clear = clr; reset = rst;
    @(posedge clk);
    model_step(code, clr, rst);
    #1;
    expect_out("model", m_ok, m_err, m_cause, m_stage, m_count, m_alarm);
  endtask

  task automatic steps(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) step(code, 1'b0, 1'b0);
  endtask

  function automatic void add(input logic [1:0] code, input logic clr, input logic rst,
                              input logic ok, input logic err, input logic [1:0] cause,
                              input logic [1:0] stg, input logic [1:0] cnt, input logic alm);
    vec_t v;
    v.code = code; v.clr = clr; v.rst = rst; v.ok = ok; v.err = err;
    v.cause = cause; v.stage = stg; v.count = cnt; v.alarm = alm;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [1:0] rc;
    int         len;
    logic       mclr;

    // Escalation table: three SHORT failures separated by clears, saturation, then reset.
    add(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 4; j++)
        add(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'(r), 1'b0);
      add(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'd0, 2'(r + 1), (r == 2));
      add(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'(r + 1), (r == 2));
    end
    add(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'd0, 2'd3, 1'b1);
    add(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1);
    add(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);

    time_lock_in = 2'b00; clear = 1'b0; reset = 1'b1;
    step(2'b00, 1'b0, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].code, tbl[i].clr, tbl[i].rst);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].ok, tbl[i].err, tbl[i].cause,
                 tbl[i].stage, tbl[i].count, tbl[i].alarm);
    end

    // Nominal stream.
    step(2'b00, 1'b0, 1'b1);
    steps(2'b00, 3);
    steps(2'b01, 5);
    expect_out("nom.st1", 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    steps(2'b10, 1);
    expect_out("nom.st2", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0);
    steps(2'b10, 4);
    steps(2'b11, 5);
    expect_out("nom.st3", 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0);
    steps(2'b00, 1);
    expect_out("nom.pass", 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0);
    steps(2'b10, 2);
    expect_out("nom.sticky", 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0);

    // LONG, then two ORDER cases; the third failure raises alarm.
    step(2'b00, 1'b0, 1'b1);
    steps(2'b01, 5);
    steps(2'b10, 5);
    expect_out("long.pre", 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0);
    steps(2'b10, 1);
    expect_out("long", 1'b0, 1'b1, 2'b11, 2'd1, 2'd1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    steps(2'b00, 1);
    steps(2'b11, 1);
    expect_out("order.idle", 1'b0, 1'b1, 2'b01, 2'd0, 2'd2, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    steps(2'b01, 5);
    steps(2'b11, 1);
    expect_out("order.st1", 1'b0, 1'b1, 2'b01, 2'd0, 2'd3, 1'b1);

    // Clear colliding with a code mid-ST2, then a nominal pass.
    step(2'b00, 1'b0, 1'b1);
    steps(2'b01, 1);
    steps(2'b10, 1);
    expect_out("coll.short", 1'b0, 1'b1, 2'b10, 2'd0, 2'd1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    steps(2'b01, 5);
    steps(2'b10, 2);
    step(2'b00, 1'b1, 1'b0);
    expect_out("coll.clear", 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0);
    steps(2'b01, 5);
    steps(2'b10, 5);
    steps(2'b11, 5);
    steps(2'b00, 1);
    expect_out("coll.pass", 1'b1, 1'b0, 2'd0, 2'd3, 2'd1, 1'b0);

    // Randomized near-nominal streams with mutated codes, odd dwells, clears and resets.
    for (int ep = 0; ep < 150; ep++) begin
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) step(rc, 1'($urandom_range(0, 1)), 1'b1);
      else step(rc, 1'b1, 1'b0);
      steps(2'b00, $urandom_range(0, 2));
      for (int k = 1; k <= 3; k++) begin
        case ($urandom_range(0, 7))
          5:       len = DWELL - 1;
          6:       len = DWELL + 1;
          7:       len = $urandom_range(1, DWELL + 2);
          default: len = DWELL;
        endcase
        rc = 2'(k);
        if ($urandom_range(0, 11) == 0) rc = 2'($urandom_range(0, 3));
        for (int j = 0; j < len; j++) begin
          mclr = ($urandom_range(0, 79) == 0);
          step(rc, mclr, 1'b0);
        end
      end
      steps(2'b00, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
